// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the mesh NoC model: header layout, terminal
// index <-> {row,col} mapping and the broadcast test.
package mesh_noc_pkg;

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;
   localparam int NT       = 2*DEF_ROWS + 2*DEF_COLS;

   // Header fields, offsets counted down from the packet MSB
   localparam int NXT_W    = 8;
   localparam int ROW_W    = 4;
   localparam int COL_W    = 4;
   localparam int DEST_W   = ROW_W + COL_W;
   localparam int DEST_OFS = NXT_W;
   localparam int MODE_OFS = NXT_W + DEST_W;

   function automatic int nt_of(input int rows, input int cols);
      return 2*rows + 2*cols;
   endfunction

   // Returns the terminal index for a {row,col} address, or -1 if none matches
   function automatic int addr_to_term(input logic [DEST_W-1:0] dest, input int rows, input int cols);
      int r;
      int c;
      r = int'(dest[DEST_W-1 -: ROW_W]);
      c = int'(dest[COL_W-1:0]);
      if (r == 0 && c >= 1 && c <= cols) return c - 1;
      if (c == 0 && r >= 1 && r <= rows) return cols + r - 1;
      if (r == rows + 1 && c >= 1 && c <= cols) return cols + rows + c - 1;
      if (c == cols + 1 && r >= 1 && r <= rows) return 2*cols + rows + r - 1;
      return -1;
   endfunction

   function automatic logic [DEST_W-1:0] term_to_addr(input int t, input int rows, input int cols);
      int r;
      int c;
      if (t < cols) begin
         r = 0;
         c = t + 1;
      end else if (t < cols + rows) begin
         r = t - cols + 1;
         c = 0;
      end else if (t < 2*cols + rows) begin
         r = rows + 1;
         c = t - cols - rows + 1;
      end else begin
         r = t - 2*cols - rows + 1;
         c = cols + 1;
      end
      return {ROW_W'(r), COL_W'(c)};
   endfunction

   function automatic logic is_bcast(input logic [DEST_W-1:0] dest, input logic [DEST_W-1:0] bc);
      return dest == bc;
   endfunction

endpackage

// File: rtl/mesh_noc_out_fifo.sv
// One terminal output: round-robin arbiter over unicast requesters feeding a
// first-word-fall-through FIFO; broadcast writes arrive pre-arbitrated.
module mesh_noc_out_fifo
   import mesh_noc_pkg::*;
#(
   parameter int N_IN  = 16,
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN-1:0]       req,
   input  logic [N_IN*WIDTH-1:0] data_in,
   input  logic                  bc_we,
   input  logic [WIDTH-1:0]      bc_data,
   input  logic                  pop,
   output logic [N_IN-1:0]       gnt,
   output logic                  space,
   output logic [WIDTH-1:0]      data_out,
   output logic                  pndng
);

   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             uc_win, wr_en, rd_en;
   logic [WIDTH-1:0] uc_data, wr_data;

   // Space uses the pre-edge count, so a same-cycle pop never frees a slot
   assign space    = (cnt_q < CW'(DEPTH));
   assign pndng    = (cnt_q != '0);
   assign data_out = pndng ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      int cand;
      cand     = 0;
      gnt      = '0;
      uc_win   = 1'b0;
      uc_data  = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < N_IN; k++) begin
         cand = (int'(rr_ptr_q) + k) % N_IN;
         if (space && !uc_win && req[cand]) begin
            uc_win    = 1'b1;
            gnt[cand] = 1'b1;
            uc_data   = data_in[cand*WIDTH +: WIDTH];
            rr_ptr_d  = IW'((cand + 1) % N_IN);
         end
      end
   end

   assign wr_en   = uc_win | (bc_we & space);
   assign wr_data = uc_win ? uc_data : bc_data;
   assign rd_en   = pop & pndng;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/mesh_noc_model.sv
// Single-stage crossbar model of a ROWS x COLUMS mesh NoC: decodes each
// terminal's head header, arbitrates unicasts per output and broadcasts globally.
module mesh_noc_model
   import mesh_noc_pkg::*;
#(
   parameter int         ROWS       = 4,
   parameter int         COLUMS     = 4,
   parameter int         pckg_sz    = 40,
   parameter int         fifo_depth = 4,
   parameter logic [7:0] bdcst      = 8'hFF,
   localparam int        NTL        = nt_of(ROWS, COLUMS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NTL*pckg_sz-1:0]   data_out_i_in,
   input  logic [NTL-1:0]           pndng_i_in,
   output logic [NTL-1:0]           popin,
   output logic [NTL*pckg_sz-1:0]   data_out,
   output logic [NTL-1:0]           pndng,
   input  logic [NTL-1:0]           pop
);

   localparam int IW = $clog2(NTL);

   logic [NTL-1:0]     req_t [NTL];
   logic [NTL-1:0]     gnt_t [NTL];
   logic [NTL-1:0]     space, bc_we, bc_req, drop, uc_gnt;
   logic [IW-1:0]      bc_ptr_q, bc_ptr_d;
   logic               bc_ok;
   logic [pckg_sz-1:0] bc_data;
   int                 bc_sel;

   always_comb begin
      logic [DEST_W-1:0] dest;
      int term;
      dest   = '0;
      term   = 0;
      bc_req = '0;
      drop   = '0;
      for (int j = 0; j < NTL; j++) req_t[j] = '0;
      for (int i = 0; i < NTL; i++) begin
         dest = data_out_i_in[i*pckg_sz + pckg_sz-1-DEST_OFS -: DEST_W];
         term = addr_to_term(dest, ROWS, COLUMS);
         if (pndng_i_in[i]) begin
            if (is_bcast(dest, bdcst)) bc_req[i] = 1'b1;
            else if (term < 0)         drop[i]   = 1'b1;
            else                       req_t[term][i] = 1'b1;
         end
      end
   end

   // One broadcast candidate per cycle; it yields to any unicast aimed at its targets
   always_comb begin
      int cand;
      cand   = 0;
      bc_sel = 0;
      bc_ok  = 1'b0;
      for (int k = 0; k < NTL; k++) begin
         cand = (int'(bc_ptr_q) + k) % NTL;
         if (!bc_ok && bc_req[cand]) begin
            bc_ok  = 1'b1;
            bc_sel = cand;
         end
      end
      for (int j = 0; j < NTL; j++) begin
         if (j != bc_sel && (!space[j] || req_t[j] != '0)) bc_ok = 1'b0;
      end
      bc_we = '0;
      for (int j = 0; j < NTL; j++) bc_we[j] = bc_ok && (j != bc_sel);
      bc_data  = data_out_i_in[bc_sel*pckg_sz +: pckg_sz];
      bc_ptr_d = bc_ok ? IW'((bc_sel + 1) % NTL) : bc_ptr_q;
   end

   always_comb begin
      uc_gnt = '0;
      for (int j = 0; j < NTL; j++) uc_gnt = uc_gnt | gnt_t[j];
      popin = uc_gnt | drop;
      if (bc_ok) popin[bc_sel] = 1'b1;
      if (reset) popin = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) bc_ptr_q <= '0;
      else       bc_ptr_q <= bc_ptr_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NTL; gi++) begin : g_out
         mesh_noc_out_fifo #(
            .N_IN  (NTL),
            .WIDTH (pckg_sz),
            .DEPTH (fifo_depth)
         ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .req      (req_t[gi]),
            .data_in  (data_out_i_in),
            .bc_we    (bc_we[gi]),
            .bc_data  (bc_data),
            .pop      (pop[gi]),
            .gnt      (gnt_t[gi]),
            .space    (space[gi]),
            .data_out (data_out[gi*pckg_sz +: pckg_sz]),
            .pndng    (pndng[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_mesh_noc_model.sv
// Bench for mesh_noc_model: directed vector table, arbitration/full/reset
// sequences, then random traffic against a queue-based delivery model.
module tb_mesh_noc_model;

   localparam int NT = 16;
   localparam int W  = 40;

   logic            clk = 1'b0;
   logic            reset;
   logic [NT*W-1:0] data_out_i_in, data_out;
   logic [NT-1:0]   pndng_i_in, popin, pndng, pop;

   int errors = 0;
   int checks = 0;

   logic [7:0] addr_of [NT];
   logic [7:0] inval [4];
   logic [W-1:0] src_q [NT][$];
   logic [W-1:0] exp_q [NT][NT][$];

   typedef struct {
      int            src;
      logic [W-1:0]  pkt;
      logic [NT-1:0] mask;
   } vec_t;
   vec_t vecs [8];

   int           sent, k, bad, left, order [3];
   logic         tk, done;
   logic [NT-1:0] took;
   logic [W-1:0] pk [5];
   logic [W-1:0] cp [3];
   logic [W-1:0] d, p, e;
   logic [7:0]   dest;

   always #5 clk = ~clk;

   mesh_noc_model #(
      .ROWS(4), .COLUMS(4), .pckg_sz(W), .fifo_depth(4), .bdcst(8'hFF)
   ) dut (
      .clk(clk), .reset(reset), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
      .popin(popin), .data_out(data_out), .pndng(pndng), .pop(pop)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   function automatic int tb_term(input logic [7:0] a);
      for (int t = 0; t < NT; t++) if (addr_of[t] == a) return t;
      return -1;
   endfunction

   function automatic logic [W-1:0] slice(input int j);
      return data_out[j*W +: W];
   endfunction

   task automatic drive(input int i, input logic [W-1:0] v);
      data_out_i_in[i*W +: W] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pndng_i_in = '0;
      pop = '0;
      data_out_i_in = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      // Terminal address table written out side by side
      for (int t = 0; t < 4; t++) begin
         addr_of[t]      = {4'd0, 4'(t + 1)};
         addr_of[t + 4]  = {4'(t + 1), 4'd0};
         addr_of[t + 8]  = {4'd5, 4'(t + 1)};
         addr_of[t + 12] = {4'(t + 1), 4'd5};
      end
      inval = '{8'h00, 8'h05, 8'h66, 8'h60};

      vecs[0] = '{0,  40'h0052012345, 16'h0200};
      vecs[1] = '{4,  40'h1110ABCDEF, 16'h0010};
      vecs[2] = '{5,  40'h22FF800001, 16'hFFDF};
      vecs[3] = '{2,  40'h3300123456, 16'h0000};
      vecs[4] = '{15, 40'h4401654321, 16'h0001};
      vecs[5] = '{8,  40'h55450F0F0F, 16'h8000};
      vecs[6] = '{11, 40'h6635F0F0F0, 16'h4000};
      vecs[7] = '{7,  40'h7750777777, 16'h0000};

      // Reset with every input requesting
      reset = 1'b1;
      pndng_i_in = '1;
      data_out_i_in = '1;
      pop = '1;
      cyc();
      cyc();
      settle();
      chk("rst_popin", 64'(popin), 64'd0);
      chk("rst_pndng", 64'(pndng), 64'd0);
      chk("rst_dout", 64'(|data_out), 64'd0);
      reset = 1'b0;
      pndng_i_in = '0;
      data_out_i_in = '0;
      pop = '0;
      cyc();
      settle();
      chk("idle_popin", 64'(popin), 64'd0);
      chk("idle_pndng", 64'(pndng), 64'd0);

      // Single-packet vector table
      for (int v = 0; v < 8; v++) begin
         cyc();
         pndng_i_in[vecs[v].src] = 1'b1;
         drive(vecs[v].src, vecs[v].pkt);
         settle();
         chk("tbl_popin", 64'(popin), 64'd1 << vecs[v].src);
         cyc();
         pndng_i_in = '0;
         data_out_i_in = '0;
         settle();
         chk("tbl_popin_once", 64'(popin), 64'd0);
         chk("tbl_pndng", 64'(pndng), 64'(vecs[v].mask));
         bad = -1;
         for (int j = 0; j < NT; j++) begin
            e = vecs[v].mask[j] ? vecs[v].pkt : '0;
            if (slice(j) !== e) bad = j;
         end
         checks++;
         if (bad >= 0) begin
            errors++;
            e = vecs[v].mask[bad] ? vecs[v].pkt : '0;
            $display("FAIL tbl_data vec=%0d term=%0d actual=%h required=%h", v, bad, slice(bad), e);
         end
         pop = vecs[v].mask;
         cyc();
         pop = '0;
         settle();
         chk("tbl_drained", 64'(pndng), 64'd0);
      end

      // Three sources contend for terminal 9
      do_reset();
      order = '{0, 4, 12};
      cp = '{40'hA052000000, 40'hB052000001, 40'hC052000002};
      for (int n = 0; n < 3; n++) begin
         pndng_i_in[order[n]] = 1'b1;
         drive(order[n], cp[n]);
      end
      k = 0;
      for (int c = 0; c < 8; c++) begin
         settle();
         if (popin != '0) begin
            if (k < 3) chk("rr_order", 64'(popin), 64'd1 << order[k]);
            else       chk("rr_extra", 64'(popin), 64'd0);
            k++;
         end
         took = popin;
         cyc();
         pndng_i_in = pndng_i_in & ~took;
      end
      chk("rr_grants", 64'(k), 64'd3);
      for (int n = 0; n < 3; n++) begin
         settle();
         chk("rr_out", 64'(slice(9)), 64'(cp[n]));
         pop[9] = 1'b1;
         cyc();
         pop = '0;
      end
      settle();
      chk("rr_empty", 64'(pndng[9]), 64'd0);

      // Terminal 3 overfills terminal 9's FIFO
      do_reset();
      for (int n = 0; n < 5; n++) pk[n] = {8'(n), 8'h52, 24'(n*3 + 1)};
      sent = 0;
      for (int c = 0; c < 8; c++) begin
         pndng_i_in[3] = (sent < 5);
         drive(3, pk[(sent < 5) ? sent : 4]);
         settle();
         tk = popin[3];
         cyc();
         if (tk) sent++;
      end
      chk("full_accepted", 64'(sent), 64'd4);
      pndng_i_in[3] = 1'b1;
      drive(3, pk[4]);
      pop[9] = 1'b1;
      settle();
      chk("full_pndng", 64'(pndng[9]), 64'd1);
      chk("full_head", 64'(slice(9)), 64'(pk[0]));
      chk("full_blocked", 64'(popin[3]), 64'd0);
      cyc();
      pop = '0;
      settle();
      chk("full_after_pop", 64'(popin[3]), 64'd1);
      cyc();
      reset = 1'b1;
      pndng_i_in = '0;
      cyc();
      settle();
      chk("midrst_pndng", 64'(pndng), 64'd0);
      chk("midrst_dout", 64'(|data_out), 64'd0);
      reset = 1'b0;

      // Random traffic against per-(source,destination) expectation queues
      do_reset();
      for (int i = 0; i < NT; i++) begin
         for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 9))
               0:       dest = 8'hFF;
               1:       dest = inval[$urandom_range(0, 3)];
               default: dest = addr_of[$urandom_range(0, NT-1)];
            endcase
            src_q[i].push_back({8'($urandom), dest, 1'($urandom), 4'(i), 19'(n)});
         end
      end
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         for (int i = 0; i < NT; i++) begin
            pndng_i_in[i] = (src_q[i].size() > 0);
            drive(i, (src_q[i].size() > 0) ? src_q[i][0] : '0);
         end
         pop = (c < 1500) ? 16'($urandom) : '1;
         settle();
         for (int j = 0; j < NT; j++) begin
            if (pop[j] && pndng[j]) begin
               d = slice(j);
               if (exp_q[int'(d[22:19])][j].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rnd_unexpected term=%0d actual=%h required=none", j, d);
               end else begin
                  chk("rnd_data", 64'(d), 64'(exp_q[int'(d[22:19])][j].pop_front()));
               end
            end
         end
         for (int i = 0; i < NT; i++) begin
            if (popin[i]) begin
               if (src_q[i].size() == 0) begin
                  chk("rnd_spurious_popin", 64'(i), 64'(NT));
               end else begin
                  p = src_q[i].pop_front();
                  if (p[31:24] == 8'hFF) begin
                     for (int j = 0; j < NT; j++) if (j != i) exp_q[i][j].push_back(p);
                  end else if (tb_term(p[31:24]) >= 0) begin
                     exp_q[i][tb_term(p[31:24])].push_back(p);
                  end
               end
            end
         end
         left = 0;
         for (int i = 0; i < NT; i++) left += src_q[i].size();
         if (left == 0 && pndng == '0) done = 1'b1;
         cyc();
      end
      chk("rnd_finished", 64'(done), 64'd1);
      left = 0;
      for (int i = 0; i < NT; i++)
         for (int j = 0; j < NT; j++) left += exp_q[i][j].size();
      chk("rnd_leftover", 64'(left), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mesh_noc_model.md
Name: mesh_noc_model

Overview:
- Cycle-level behavioural model of a ROWS x COLUMS mesh network-on-chip with NT = 2*ROWS + 2*COLUMS edge terminals (16 by default).
- Each terminal injects packets through a FIFO-style pop interface and receives packets through a per-terminal output FIFO.
- Routing is resolved from the destination row/column field in the packet header. Internal hop latency is abstracted to a single crossbar stage.
- The block is the DUT wrapped by the team's interface and environment (driver/monitor per terminal).

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- pckg_sz, 40, packet width in bits; must be >= 24.
- fifo_depth, 4, entries per terminal output FIFO.
- bdcst, 8'hFF, destination {row,col} value that means broadcast.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_out_i_in  in  NT*pckg_sz  terminal i source word, slice [i*pckg_sz +: pckg_sz]; first-word-fall-through, valid while pndng_i_in[i]=1.
- pndng_i_in  in  NT  terminal i has a packet to inject.
- popin  out  NT  DUT consumes terminal i's head word at this rising edge.
- data_out  out  NT*pckg_sz  head of output FIFO j.
- pndng  out  NT  output FIFO j non-empty.
- pop  in  NT  terminal j removes the head of output FIFO j.

Behaviour:
Header fields:
- [pckg_sz-1:pckg_sz-8] nxt_jump: ignored by the DUT, passed through.
- [pckg_sz-9:pckg_sz-12] dest row.
- [pckg_sz-13:pckg_sz-16] dest col.
- [pckg_sz-17] mode: passed through.
- Remaining bits: payload.
- Packets are delivered bit-for-bit unmodified.

Terminal addressing (defaults shown):
- Terminals 0..COLUMS-1: row 0, col 1..COLUMS.
- Next ROWS terminals: row 1..ROWS, col 0.
- Next COLUMS terminals: row ROWS+1, col 1..COLUMS.
- Last ROWS terminals: row 1..ROWS, col COLUMS+1.
- Example: terminal 9 = (row 5, col 2).

Routing and arbitration:
- A {row,col} matching no terminal and not equal to bdcst is invalid: the packet is popped and discarded.
- Each cycle, each output FIFO j accepts at most one packet. Requesters are all inputs with pndng_i_in=1 whose destination is j.
- Arbitration per output is round-robin, starting at the index after the last grantee. Pointers reset to 0.
- popin[i] is combinational and asserts only in the cycle input i is granted and the target FIFO(s) have space. The word is captured at that rising edge.
- Unicast to self is allowed.
- Broadcast writes to every FIFO except the source's. It is granted only when all those FIFOs have space and no unicast to them wins this cycle; unicasts take priority over broadcast.
- Space is evaluated on the pre-edge count: a full FIFO does not accept a write even when popped in the same cycle.

Output side:
- Output FIFO: pndng rises one cycle after the capture edge.
- data_out[j] shows the head; it is 0 when empty.
- pop[j] with pndng[j]=1 advances the FIFO at the edge. pop on an empty FIFO is ignored.
- Order is preserved per source→destination pair.

Reset:
- While reset=1: popin=0, all FIFOs empty, pndng=0, data_out=0, arbiter pointers=0.
- Reset asserted mid-operation discards all in-flight packets at that edge.

Decomposition:
- Package mesh_noc_pkg holds: NT, header field bit positions, the terminal-index↔{row,col} mapping function, and the broadcast test function.
- Sub-module mesh_noc_out_fifo (fifo_depth-deep first-word-fall-through FIFO plus its round-robin arbiter), instantiated NT times.

Test Plan:
- Reset for 1 cycle, then idle → popin=0, pndng=0, data_out=0 on all terminals.
- Terminal 0 injects 40'h0052012345 (dest row 5, col 2 = terminal 9) → popin[0] pulses once; pndng[9]=1 the next cycle with data_out slice 9 = 40'h0052012345; pop[9] → pndng[9]=0.
- Terminals 0, 4 and 12 all target terminal 9 in the same cycle → one grant per cycle, delivered in round-robin order 0, 4, 12.
- Terminal 3 sends 5 packets to terminal 9 with no pop and fifo_depth=4 → 4 accepted; popin[3] stays 0 for the 5th until pop[9] frees an entry.
- Terminal 5 sends dest 8'hFF → all terminals except 5 show the packet, pndng[5]=0.
- Dest {row 0, col 0} (invalid) → popped once, no pndng anywhere; reset asserted while FIFOs hold data → all pndng=0 after the edge.
